lif_pixel_sequencer: RTL and testbench
======================================

LIF_PIXEL_SEQUENCER -- requirements
Module: lif_pixel_sequencer

Interface
REQ-001 Parameter N_STEPS, default 64, time steps per pixel when cfg_steps = 0.
REQ-002 Parameter STEP_DIV, default 2, clocks per time step; legal range 1..255.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 pix_valid  in  1  upstream pixel available.
REQ-006 pix_data  in  8  pixel intensity.
REQ-007 pix_ready  out  1  sequencer can accept a pixel.
REQ-008 cfg_threshold  in  8  neuron threshold, sampled at pixel accept.
REQ-009 cfg_steps  in  8  steps per pixel, sampled at accept; 0 selects N_STEPS.
REQ-010 data_en  out  1  neuron evaluation enable.
REQ-011 step_en  out  1  one-cycle step strobe to the neuron.
REQ-012 clear_spike  out  1  one-cycle acknowledge of neuron spike_out.
REQ-013 end_step  out  1  one-cycle end-of-pixel clear to the neuron.
REQ-014 input_current  out  8  latched pixel value.
REQ-015 threshold  out  8  latched cfg_threshold.
REQ-016 sp_steps  out  8  latched effective step count.
REQ-017 spike_out  in  1  neuron spike flag (registered in the neuron).
REQ-018 spike_count  in  8  neuron spike count (registered in the neuron).
REQ-019 res_valid  out  1  result available.
REQ-020 res_count  out  8  captured spike_count.
REQ-021 res_events  out  8  number of clear_spike pulses issued for this pixel; saturates at 255.
REQ-022 res_ready  in  1  downstream accepts result.
REQ-023 busy  out  1  high in every state except IDLE.

Function
REQ-024 FSM states: IDLE, ARM, RUN, DRAIN, RESULT, END.
REQ-025 IDLE: pix_ready = 1; on pix_valid = 1, latch pix_data, cfg_threshold and effective steps, clear res_events, go to ARM.
REQ-026 pix_ready = 0 in all non-IDLE states; pix_valid is ignored there.
REQ-027 ARM: one cycle with data_en = 1 and step_en = 0, giving the neuron a data_en rising edge; go to RUN.
REQ-028 RUN: data_en = 1; step_en pulses in the first RUN cycle, then every STEP_DIV cycles.
REQ-029 STEP_DIV = 1 keeps step_en high for every RUN cycle.
REQ-030 Step counter increments on each step_en; after exactly sp_steps pulses, go to DRAIN in the cycle following the last pulse.
REQ-031 spike_out is registered internally; clear_spike is high for one cycle, the cycle after spike_out is sampled 1 with the previous sample 0.
REQ-032 Each clear_spike increments res_events; this applies in RUN, DRAIN and RESULT.
REQ-033 DRAIN: lasts 2 cycles with data_en = 1; at the end of the 2nd cycle, capture spike_count into res_count and go to RESULT.
REQ-034 RESULT: res_valid = 1 and data_en = 1; res_count and res_events are held stable until res_ready = 1 is sampled, then go to END.
REQ-035 END: one cycle with end_step = 1 and data_en = 0, then go to IDLE.
REQ-036 A new pixel is accepted no earlier than the IDLE cycle after END.
REQ-037 input_current, threshold and sp_steps stay constant from accept until the next accept.

Reset
REQ-038 On reset = 1, all outputs are 0, the FSM is IDLE, and all counters and registers are 0.
REQ-039 Reset mid-operation in any state aborts the pixel with no res_valid.
REQ-040 After reset deasserts, pix_ready = 1 on the first clock.

Verification
REQ-041 Pixel 0x00, cfg_steps = 0, spike_out tied 0 -> exactly 64 step_en pulses spaced 2 cycles; res_count = 0, res_events = 0; one end_step.
REQ-042 cfg_steps = 10, STEP_DIV = 1 -> 10 consecutive step_en cycles, then 2 DRAIN cycles, then res_valid; spike_count = 0x07 at capture gives res_count = 0x07.
REQ-043 spike_out pulsed high for 3 rising edges during RUN -> 3 single-cycle clear_spike pulses, each one cycle after the sampled edge; res_events = 3.
REQ-044 res_ready held 0 for 20 cycles -> res_valid and values stable for 20 cycles; pix_ready = 0 throughout; END occurs after res_ready = 1.
REQ-045 reset asserted at the 5th step_en -> all outputs 0 immediately; after release a new pixel 0x80 completes normally.
REQ-046 pix_valid held high continuously -> next accept occurs only in the IDLE cycle after end_step; threshold tracks the cfg_threshold value present at each accept.

Source files
------------

// File: rtl/lif_pixel_sequencer_if.sv
// Pixel-in / result-out handshake bundle between the upstream source, the
// LIF pixel sequencer and the downstream result consumer.
interface lif_pixel_sequencer_if;
  localparam int unsigned DW = 8;

  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic [DW-1:0] cfg_threshold;
  logic [DW-1:0] cfg_steps;
  logic          res_valid;
  logic [DW-1:0] res_count;
  logic [DW-1:0] res_events;
  logic          res_ready;

  modport master (
    output pix_valid, pix_data, cfg_threshold, cfg_steps, res_ready,
    input  pix_ready, res_valid, res_count, res_events
  );

  modport slave (
    input  pix_valid, pix_data, cfg_threshold, cfg_steps, res_ready,
    output pix_ready, res_valid, res_count, res_events
  );
endinterface

// File: rtl/lif_pixel_sequencer.sv
// Sequences one pixel through a LIF neuron: arms data_en, issues sp_steps
// step strobes, acknowledges spikes, drains, reports the result, then clears.
module lif_pixel_sequencer #(
  parameter int unsigned N_STEPS  = 64,
  parameter int unsigned STEP_DIV = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  lif_pixel_sequencer_if.slave         bus,
  output logic                         data_en,
  output logic                         step_en,
  output logic                         clear_spike,
  output logic                         end_step,
  output logic [7:0]                   input_current,
  output logic [7:0]                   threshold,
  output logic [7:0]                   sp_steps,
  input  logic                         spike_out,
  input  logic [7:0]                   spike_count,
  output logic                         busy
);

  localparam int unsigned DW       = 8;
  localparam int unsigned CW       = DW + 1;
  localparam logic [DW-1:0] N_EFF    = DW'(N_STEPS);
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
  localparam logic [DW-1:0] SAT      = {DW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RUN, S_DRAIN, S_RESULT, S_END
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [DW-1:0] step_cnt_q, step_cnt_d;
  logic          drain_q, drain_d;
  logic          spike_s_q;
  logic [DW-1:0] input_current_q, input_current_d;
  logic [DW-1:0] threshold_q, threshold_d;
  logic [DW-1:0] sp_steps_q, sp_steps_d;
  logic [DW-1:0] res_count_q, res_count_d;
  logic [DW-1:0] res_events_q, res_events_d;
  logic          pix_ready_q, pix_ready_d;
  logic          busy_q, busy_d;
  logic          data_en_q, data_en_d;
  logic          step_en_q, step_en_d;
  logic          clear_spike_q, clear_spike_d;
  logic          end_step_q, end_step_d;
  logic          res_valid_q, res_valid_d;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d         = state_q;
    div_d           = div_q;
    step_cnt_d      = step_cnt_q;
    drain_d         = drain_q;
    input_current_d = input_current_q;
    threshold_d     = threshold_q;
    sp_steps_d      = sp_steps_q;
    res_count_d     = res_count_q;
    res_events_d    = res_events_q;

    // Spike acknowledge fires on a rising edge of the sampled spike flag
    clear_spike_d = spike_out && !spike_s_q &&
                    (state_q inside {S_RUN, S_DRAIN, S_RESULT});
    if (clear_spike_d && (res_events_q != SAT)) begin
      res_events_d = res_events_q + DW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.pix_valid && pix_ready_q) begin
          input_current_d = bus.pix_data;
          threshold_d     = bus.cfg_threshold;
          sp_steps_d      = (bus.cfg_steps == '0) ? N_EFF : bus.cfg_steps;
          res_events_d    = '0;
          step_cnt_d      = '0;
          div_d           = '0;
          state_d         = S_ARM;
        end
      end
      S_ARM: begin
        div_d      = '0;
        step_cnt_d = '0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (step_en_q) begin
          step_cnt_d = step_cnt_q + DW'(1);
        end
        if (step_en_q && ((CW'(step_cnt_q) + CW'(1)) == CW'(sp_steps_q))) begin
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          res_count_d = spike_count;
          state_d     = S_RESULT;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_RESULT: begin
        if (bus.res_ready) begin
          state_d = S_END;
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    pix_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    data_en_d   = state_d inside {S_ARM, S_RUN, S_DRAIN, S_RESULT};
    step_en_d   = (state_d == S_RUN) && (div_d == '0);
    end_step_d  = (state_d == S_END);
    res_valid_d = (state_d == S_RESULT);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      div_q           <= '0;
      step_cnt_q      <= '0;
      drain_q         <= 1'b0;
      spike_s_q       <= 1'b0;
      input_current_q <= '0;
      threshold_q     <= '0;
      sp_steps_q      <= '0;
      res_count_q     <= '0;
      res_events_q    <= '0;
      pix_ready_q     <= 1'b0;
      busy_q          <= 1'b0;
      data_en_q       <= 1'b0;
      step_en_q       <= 1'b0;
      clear_spike_q   <= 1'b0;
      end_step_q      <= 1'b0;
      res_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      div_q           <= div_d;
      step_cnt_q      <= step_cnt_d;
      drain_q         <= drain_d;
      spike_s_q       <= spike_out;
      input_current_q <= input_current_d;
      threshold_q     <= threshold_d;
      sp_steps_q      <= sp_steps_d;
      res_count_q     <= res_count_d;
      res_events_q    <= res_events_d;
      pix_ready_q     <= pix_ready_d;
      busy_q          <= busy_d;
      data_en_q       <= data_en_d;
      step_en_q       <= step_en_d;
      clear_spike_q   <= clear_spike_d;
      end_step_q      <= end_step_d;
      res_valid_q     <= res_valid_d;
    end
  end

  assign bus.pix_ready  = pix_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_count  = res_count_q;
  assign bus.res_events = res_events_q;
  assign data_en        = data_en_q;
  assign step_en        = step_en_q;
  assign clear_spike    = clear_spike_q;
  assign end_step       = end_step_q;
  assign input_current  = input_current_q;
  assign threshold      = threshold_q;
  assign sp_steps       = sp_steps_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_lif_pixel_sequencer.sv
// Scoreboard bench for lif_pixel_sequencer: the driver pushes expected results,
// a negedge monitor checks step cadence, spike acks and each result handshake.
module tb_lif_pixel_sequencer;
  localparam int unsigned STEP_DIV = 2;
  localparam int unsigned N_STEPS  = 64;

  typedef struct {
    logic [7:0] count;
    logic [7:0] events;
    logic [7:0] cur;
    logic [7:0] thr;
    logic [7:0] steps;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       data_en, step_en, clear_spike, end_step, busy;
  logic [7:0] input_current, threshold, sp_steps;
  logic       spike_out;
  logic [7:0] spike_count;

  lif_pixel_sequencer_if bus ();

  lif_pixel_sequencer #(.N_STEPS(N_STEPS), .STEP_DIV(STEP_DIV)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .data_en       (data_en),
    .step_en       (step_en),
    .clear_spike   (clear_spike),
    .end_step      (end_step),
    .input_current (input_current),
    .threshold     (threshold),
    .sp_steps      (sp_steps),
    .spike_out     (spike_out),
    .spike_count   (spike_count),
    .busy          (busy)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {bus.pix_ready, bus.res_valid, bus.res_count, bus.res_events,
            data_en, step_en, clear_spike, end_step, busy,
            input_current, threshold, sp_steps};
  endfunction

  // Monitor state, all per pixel and cleared at accept or reset
  int   cyc = 0;
  int   steps_seen, last_step, clears_seen, drain_lat;
  bit   gap_bad, clear_bad, res_seen, exp_clear, exp_end, exp_ready;
  logic prev_spike;

  always @(negedge clk) begin
    if (reset) begin
      steps_seen = 0; last_step = 0; clears_seen = 0; drain_lat = 0;
      gap_bad = 0; clear_bad = 0; res_seen = 0;
      exp_clear = 0; exp_end = 0; exp_ready = 0; prev_spike = 1'b0;
    end else begin
      cyc++;
      if (clear_spike !== exp_clear) clear_bad = 1;
      if (clear_spike) clears_seen++;
      if (step_en) begin
        if (steps_seen > 0 && (cyc - last_step) != int'(STEP_DIV)) gap_bad = 1;
        last_step = cyc;
        steps_seen++;
      end
      if (bus.res_valid && !res_seen) begin
        res_seen  = 1;
        drain_lat = cyc - last_step;
      end
      if (exp_end) begin
        check("end_step", end_step, 1);
        check("end_data_en", data_en, 0);
        exp_end   = 0;
        exp_ready = 1;
      end else begin
        if (end_step) check("end_step_spurious", 1, 0);
        if (exp_ready) begin
          check("ready_after_end", bus.pix_ready, 1);
          exp_ready = 0;
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("res_count", bus.res_count, e.count);
          check("res_events", bus.res_events, e.events);
          check("input_current", input_current, e.cur);
          check("threshold", threshold, e.thr);
          check("sp_steps", sp_steps, e.steps);
          check("step_pulses", steps_seen, e.steps);
          check("step_gap_ok", gap_bad, 0);
          check("clear_timing_ok", clear_bad, 0);
          check("clear_pulses", clears_seen, e.events);
          check("drain_latency", drain_lat, 3);
        end
        exp_end = 1;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        steps_seen = 0; last_step = 0; clears_seen = 0; drain_lat = 0;
        gap_bad = 0; clear_bad = 0; res_seen = 0;
      end
      // Ack expected next cycle for a rising spike while the step phase is live
      exp_clear  = spike_out && !prev_spike && data_en && (step_en || steps_seen > 0);
      prev_spike = spike_out;
    end
  end

  task automatic wait_end(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (end_step) begin ok = 1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic wait_accept(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.pix_ready) begin ok = 1; break; end
    end
  endtask

  task automatic send_pixel(input logic [7:0] data, input logic [7:0] thr,
                            input logic [7:0] steps, input logic [7:0] cnt,
                            input int pulses, input int hold);
    exp_t e;
    bit   ok, stable;
    logic [7:0] c0, e0;
    e.count  = cnt;
    e.events = 8'(pulses);
    e.cur    = data;
    e.thr    = thr;
    e.steps  = (steps == 8'd0) ? 8'(N_STEPS) : steps;
    sb.push_back(e);
    spike_count       = cnt;
    bus.pix_data      = data;
    bus.cfg_threshold = thr;
    bus.cfg_steps     = steps;
    bus.pix_valid     = 1'b1;
    bus.res_ready     = (hold == 0);
    wait_accept(ok);
    @(posedge clk); #1;
    bus.pix_valid     = 1'b0;
    bus.pix_data      = ~data;
    bus.cfg_threshold = ~thr;
    bus.cfg_steps     = 8'd3;
    if (!ok) begin
      check("accept_timeout", 0, 1);
      void'(sb.pop_back());
      return;
    end
    repeat (5) @(posedge clk);
    #1;
    for (int p = 0; p < pulses; p++) begin
      spike_out = 1'b1;
      @(posedge clk); #1;
      spike_out = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    if (hold > 0) begin
      ok = 0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (bus.res_valid) begin ok = 1; break; end
      end
      check("res_valid_timeout", ok, 1);
      c0 = bus.res_count;
      e0 = bus.res_events;
      stable = 1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!bus.res_valid || bus.res_count != c0 || bus.res_events != e0 ||
            bus.pix_ready || end_step) stable = 0;
      end
      check("hold_stable", stable, 1);
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
    end
    wait_end("end_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, early;
    int cnt;
    reset             = 1'b1;
    spike_out         = 1'b0;
    spike_count       = 8'd0;
    bus.pix_valid     = 1'b0;
    bus.pix_data      = 8'd0;
    bus.cfg_threshold = 8'd0;
    bus.cfg_steps     = 8'd0;
    bus.res_ready     = 1'b1;
    #1;
    check("reset_outputs_zero", all_outputs(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_held_zero", all_outputs(), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("pix_ready_after_reset", bus.pix_ready, 1);
    check("busy_idle", busy, 0);

    // Dark pixel, default step count, no spikes
    send_pixel(8'h00, 8'h10, 8'd0, 8'h00, 0, 0);
    // Short pixel with a spike count to capture
    send_pixel(8'h5A, 8'h40, 8'd10, 8'h07, 0, 0);
    // Three spike edges during RUN
    send_pixel(8'h99, 8'h20, 8'd12, 8'h03, 3, 0);
    // Consumer stalls for 20 cycles
    send_pixel(8'h21, 8'h30, 8'd6, 8'h02, 1, 20);

    // Abort with reset on the 5th step strobe
    begin
      exp_t e;
      e.count = 8'h00; e.events = 8'h00; e.cur = 8'h44; e.thr = 8'h50; e.steps = 8'd64;
      sb.push_back(e);
      bus.pix_data = 8'h44; bus.cfg_threshold = 8'h50; bus.cfg_steps = 8'd0;
      bus.pix_valid = 1'b1;
      wait_accept(ok);
      @(posedge clk); #1;
      bus.pix_valid = 1'b0;
      cnt = 0;
      for (int i = 0; i < 200 && cnt < 5; i++) begin
        @(negedge clk);
        if (step_en) cnt++;
      end
      check("fifth_step_seen", cnt, 5);
      reset = 1'b1;
      #1;
      check("abort_outputs_zero", all_outputs(), 0);
      void'(sb.pop_back());
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("pix_ready_after_abort", bus.pix_ready, 1);
    end
    send_pixel(8'h80, 8'h60, 8'd0, 8'h10, 2, 0);

    // pix_valid held high across two pixels; threshold follows each accept
    begin
      exp_t e;
      e.count = 8'h00; e.events = 8'h00; e.cur = 8'h33; e.thr = 8'h11; e.steps = 8'd4;
      sb.push_back(e);
      e.thr = 8'h22;
      sb.push_back(e);
      spike_count = 8'h00;
      bus.pix_data = 8'h33; bus.cfg_threshold = 8'h11; bus.cfg_steps = 8'd4;
      bus.pix_valid = 1'b1;
      wait_accept(ok);
      check("b2b_first_accept", ok, 1);
      @(posedge clk); #1;
      bus.cfg_threshold = 8'h22;
      early = 0;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (end_step) begin ok = 1; break; end
        if (bus.pix_ready) early = 1;
      end
      check("b2b_end_seen", ok, 1);
      check("b2b_no_early_ready", early, 0);
      @(negedge clk);
      check("b2b_ready_idle", bus.pix_ready, 1);
      @(posedge clk); #1;
      bus.pix_valid = 1'b0;
      check("b2b_threshold_tracks", threshold, 8'h22);
      check("b2b_busy", busy, 1);
      wait_end("b2b_end_timeout");
      @(posedge clk); #1;
    end

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
